quad_gate_response_checker: RTL and testbench

Synthesizable self-test engine for the 74LSXX library. It drives the eight inputs of a quad 2-input gate part (74LS00/02/08/32/86 model or a physical chip on a header) and samples its four outputs. Each gate is walked through all four input combinations in turn, and every output is compared against the selected logic function. Result is a pass flag, a per-gate failure mask and a mismatch count, so a board can qualify a gate part without a simulator testbench.

---
 rtl/quad_gate_response_checker_if.sv | 39 +++
 rtl/quad_gate_response_checker.sv | 150 +++++++++++++++
 tb/tb_quad_gate_response_checker.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/quad_gate_response_checker_if.sv
// Bus bundle between the quad-gate checker and the part under test / host.
// master = checker side, slave = part/host side.
// Optional QUAD_CHECK_LOG_EN adds the first-failure log signals.
interface quad_gate_response_checker_if;
  logic       start;
  logic [2:0] func;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [6:0] err_count;
`ifdef QUAD_CHECK_LOG_EN
  logic [3:0] first_fail_vec;
  logic [3:0] first_fail_y;

  modport master (
    input  start, func, y,
    output a, b, busy, done, pass, fail_mask, err_count,
           first_fail_vec, first_fail_y
  );
  modport slave (
    output start, func, y,
    input  a, b, busy, done, pass, fail_mask, err_count,
           first_fail_vec, first_fail_y
  );
`else
  modport master (
    input  start, func, y,
    output a, b, busy, done, pass, fail_mask, err_count
  );
  modport slave (
    output start, func, y,
    input  a, b, busy, done, pass, fail_mask, err_count
  );
`endif
endinterface

// File: rtl/quad_gate_response_checker.sv
// Self-test engine for quad 2-input gate parts (74LS00/02/08/32/86).
// Walks each gate through all four input patterns, compares all four
// outputs against the selected function and reports pass / mask / count.
// Optional macro QUAD_CHECK_LOG_EN adds first-failure vector and Y capture.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for start
// S_SETTLE | vector driven, counting down the settle delay
// S_CHECK  | compare synchronized Y, accumulate results
// S_DONE   | results held, start launches a new run
module quad_gate_response_checker #(
  parameter int unsigned SETTLE = 4
) (
  input logic                          clk,
  input logic                          clr_n,
  quad_gate_response_checker_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [3:0] vec;
  logic [2:0] func_q;
  logic [3:0] y_s1;
  logic [3:0] y_s2;
  logic       armed;

  logic [3:0] exp_y;
  logic [3:0] mismatch;
  logic [2:0] mis_cnt;
  logic [6:0] err_next;
  logic [3:0] vec_nxt;

  // Only the gate selected by v[3:2] gets the pattern; the others sit at 0/0.
  function automatic logic [3:0] vec_a(input logic [3:0] v);
    return {3'b000, v[1]} << v[3:2];
  endfunction

  function automatic logic [3:0] vec_b(input logic [3:0] v);
    return {3'b000, v[0]} << v[3:2];
  endfunction

  // Expected outputs from the latched function and mismatch accumulation terms.
  always_comb begin
    case (func_q)
      3'b001:  exp_y = ~(bus.a | bus.b);
      3'b010:  exp_y = bus.a & bus.b;
      3'b011:  exp_y = bus.a | bus.b;
      3'b100:  exp_y = bus.a ^ bus.b;
      default: exp_y = ~(bus.a & bus.b);
    endcase
    mismatch = y_s2 ^ exp_y;
    mis_cnt  = {2'b00, mismatch[0]} + {2'b00, mismatch[1]} +
               {2'b00, mismatch[2]} + {2'b00, mismatch[3]};
    err_next = bus.err_count + {4'b0000, mis_cnt};
    vec_nxt  = vec + 4'd1;
  end

  // Two-flop synchronizer for the asynchronous part outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      y_s1 <= 4'b0000;
      y_s2 <= 4'b0000;
    end else begin
      y_s1 <= bus.y;
      y_s2 <= y_s1;
    end
  end

  // Sequencer: vector walk, settle timer, result accumulation.
  // armed blocks a start that lands on the reset-release edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= S_IDLE;
      cnt           <= 8'd0;
      vec           <= 4'd0;
      func_q        <= 3'd0;
      armed         <= 1'b0;
      bus.a         <= 4'b0000;
      bus.b         <= 4'b0000;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.fail_mask <= 4'b0000;
      bus.err_count <= 7'd0;
`ifdef QUAD_CHECK_LOG_EN
      bus.first_fail_vec <= 4'd0;
      bus.first_fail_y   <= 4'd0;
`endif
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start && armed) begin
            func_q        <= bus.func;
            bus.fail_mask <= 4'b0000;
            bus.err_count <= 7'd0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.busy      <= 1'b1;
            vec           <= 4'd0;
            bus.a         <= vec_a(4'd0);
            bus.b         <= vec_b(4'd0);
            cnt           <= SETTLE_LOAD;
            state         <= S_SETTLE;
`ifdef QUAD_CHECK_LOG_EN
            bus.first_fail_vec <= 4'd0;
            bus.first_fail_y   <= 4'd0;
`endif
          end
        end
        S_SETTLE: begin
          if (cnt == 8'd0) state <= S_CHECK;
          else             cnt   <= cnt - 8'd1;
        end
        S_CHECK: begin
          bus.fail_mask <= bus.fail_mask | mismatch;
          bus.err_count <= err_next;
`ifdef QUAD_CHECK_LOG_EN
          // err_count still zero means no earlier vector has mismatched.
          if (mismatch != 4'b0000 && bus.err_count == 7'd0) begin
            bus.first_fail_vec <= vec;
            bus.first_fail_y   <= y_s2;
          end
`endif
          if (vec == 4'd15) begin
            bus.a    <= 4'b0000;
            bus.b    <= 4'b0000;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (err_next == 7'd0);
            state    <= S_DONE;
          end else begin
            vec   <= vec_nxt;
            bus.a <= vec_a(vec_nxt);
            bus.b <= vec_b(vec_nxt);
            cnt   <= SETTLE_LOAD;
            state <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_gate_response_checker.sv
// Testbench for quad_gate_response_checker: behavioural gate-part model with
// injectable faults, reference result computed per run from the vector rules.
module tb_quad_gate_response_checker;

  logic clk;
  logic clr_n;
  int   total;
  int   passed;
  int   fails;

  quad_gate_response_checker_if bus ();

  quad_gate_response_checker #(.SETTLE(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate part model and fault injection.
  logic       model_xor;
  logic [3:0] stuck1;
  logic [3:0] stuck0;
  logic       short12;
  logic [3:0] y_part;

  always_comb begin
    y_part = model_xor ? (bus.a ^ bus.b) : ~(bus.a & bus.b);
    y_part = (y_part | stuck1) & ~stuck0;
    if (short12) y_part[1] = y_part[1] & y_part[0];
  end
  assign bus.y = y_part;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int vec_ab(input int v);
    int g;
    int av;
    int bv;
    g  = v / 4;
    av = (v / 2) % 2;
    bv = v % 2;
    return ((av << g) << 4) | (bv << g);
  endfunction

  // Reference outcome of a full run from the vector-walk rules.
  function automatic void ref_run(input logic [2:0] f, output logic [6:0] err,
                                  output logic [3:0] mask, output logic [3:0] fv,
                                  output logic [3:0] fy);
    bit seen;
    err  = 0;
    mask = 0;
    fv   = 0;
    fy   = 0;
    seen = 0;
    for (int v = 0; v < 16; v++) begin
      logic [3:0] yv;
      int bad;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        int ai;
        int bi;
        int good;
        ai = (i == v / 4) ? (v / 2) % 2 : 0;
        bi = (i == v / 4) ? v % 2 : 0;
        good = model_xor ? int'(ai != bi) : int'(!(ai && bi));
        if (stuck1[i]) good = 1;
        if (stuck0[i]) good = 0;
        yv[i] = good[0];
      end
      if (short12) yv[1] = yv[1] & yv[0];
      for (int i = 0; i < 4; i++) begin
        int ai;
        int bi;
        int e;
        ai = (i == v / 4) ? (v / 2) % 2 : 0;
        bi = (i == v / 4) ? v % 2 : 0;
        case (f)
          3'd1:    e = int'(!(ai || bi));
          3'd2:    e = int'(ai && bi);
          3'd3:    e = int'(ai || bi);
          3'd4:    e = int'(ai != bi);
          default: e = int'(!(ai && bi));
        endcase
        if (int'(yv[i]) != e) begin
          bad++;
          mask[i] = 1'b1;
        end
      end
      if (bad > 0 && !seen) begin
        seen = 1;
        fv   = 4'(v);
        fy   = yv;
      end
      err += 7'(bad);
    end
  endfunction

  // One complete run; mid_start pulses start again while busy.
  task automatic run(input string tag, input logic [2:0] f, input bit mid_start);
    logic [6:0] e_err;
    logic [3:0] e_mask;
    logic [3:0] e_fv;
    logic [3:0] e_fy;
    int n;
    bit got;
    ref_run(f, e_err, e_mask, e_fv, e_fy);
    @(posedge clk); #1;
    bus.func  = f;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy_rise"}, bus.busy, 1);
    chk({tag, "_done_low"}, bus.done, 0);
    chk({tag, "_vec0"}, {bus.a, bus.b}, 0);
    n   = 0;
    got = 0;
    while (n < 200 && !got) begin
      @(posedge clk); #1;
      n++;
      bus.start = (mid_start && n == 26);
      if (bus.done) got = 1;
      else if (n < 80) chk({tag, "_vec"}, {bus.a, bus.b}, vec_ab(n / 5));
    end
    bus.start = 1'b0;
    chk({tag, "_done_cycle"}, n, 80);
    chk({tag, "_busy_fall"}, bus.busy, 0);
    chk({tag, "_ab_idle"}, {bus.a, bus.b}, 0);
    chk({tag, "_err"}, bus.err_count, e_err);
    chk({tag, "_mask"}, bus.fail_mask, e_mask);
    chk({tag, "_pass"}, bus.pass, e_err == 0);
`ifdef QUAD_CHECK_LOG_EN
    chk({tag, "_ffv"}, bus.first_fail_vec, e_fv);
    chk({tag, "_ffy"}, bus.first_fail_y, e_fy);
`endif
  endtask

  task automatic set_fault(input logic mx, input logic [3:0] s1, input logic [3:0] s0,
                           input logic sh);
    model_xor = mx;
    stuck1    = s1;
    stuck0    = s0;
    short12   = sh;
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    fails     = 0;
    clr_n     = 1'b0;
    bus.start = 1'b0;
    bus.func  = 3'd0;
    set_fault(0, 4'h0, 4'h0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ab", {bus.a, bus.b}, 0);
    chk("rst_flags", {bus.busy, bus.done, bus.pass}, 0);
    chk("rst_err", {bus.fail_mask, bus.err_count}, 0);
    @(negedge clk);
    clr_n = 1'b1;
    repeat (5) @(posedge clk);

    // Healthy NAND part checked as NAND, then as AND.
    run("nand_ok", 3'd0, 0);
    chk("nand_ok_const", {bus.pass, bus.err_count}, {1'b1, 7'd0});
    run("nand_as_and", 3'd2, 0);
    chk("and_err64", bus.err_count, 7'd64);
    // Y3 stuck high, Y2 pulled down by Y1.
    set_fault(0, 4'b0100, 4'h0, 0);
    run("y3_stuck1", 3'd0, 0);
    chk("y3_mask", {bus.fail_mask, bus.err_count}, {4'b0100, 7'd1});
    set_fault(0, 4'h0, 4'h0, 1);
    run("short12", 3'd0, 0);
    chk("short_mask", {bus.fail_mask, bus.err_count}, {4'b0010, 7'd1});
    set_fault(0, 4'h0, 4'h0, 0);

    // Reset mid-run at v=7, then start coincident with release.
    @(posedge clk); #1;
    bus.func  = 3'd2;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (37) @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    chk("clr_ab", {bus.a, bus.b}, 0);
    chk("clr_busy", bus.busy, 0);
    chk("clr_err", {bus.fail_mask, bus.err_count}, 0);
    @(negedge clk);
    clr_n     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("rel_start_ignored", bus.busy, 0);
    run("after_clr", 3'd0, 0);

    // Start while busy is ignored; restart from DONE with XOR part.
    run("mid_start", 3'd0, 1);
    set_fault(1, 4'h0, 4'h0, 0);
    run("xor_ok", 3'd4, 0);

    // Randomized parts, faults and functions.
    for (int k = 0; k < 6; k++) begin
      logic [3:0] s1;
      logic [3:0] s0;
      s1 = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      s0 = ($urandom_range(0, 2) == 0) ? (4'($urandom) & ~s1) : 4'h0;
      set_fault(1'($urandom_range(0, 1)), s1, s0, 1'($urandom_range(0, 1)));
      run("rand", 3'($urandom_range(0, 7)), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
